// File: rtl/lint32_2_axi_bridge.sv
// TCDM (lint) 32-bit master port to AXI4 single-beat converter.
// One transaction in flight; the TCDM grant is only issued from IDLE.
module lint32_2_axi_bridge #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_USER_WIDTH = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      tcdm_req_i,
    input  logic [31:0]               tcdm_add_i,
    input  logic                      tcdm_wen_i,
    input  logic [31:0]               tcdm_wdata_i,
    input  logic [3:0]                tcdm_be_i,
    output logic                      tcdm_gnt_o,
    output logic                      tcdm_r_valid_o,
    output logic [31:0]               tcdm_r_rdata_o,
    output logic                      tcdm_r_opc_o,

    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [31:0]               aw_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   aw_id_o,
    output logic [AXI_USER_WIDTH-1:0] aw_user_o,
    output logic [7:0]                aw_len_o,
    output logic [2:0]                aw_size_o,
    output logic [1:0]                aw_burst_o,
    output logic [2:0]                aw_prot_o,
    output logic [3:0]                aw_cache_o,
    output logic                      aw_lock_o,
    output logic [3:0]                aw_qos_o,
    output logic [3:0]                aw_region_o,
    output logic [5:0]                aw_atop_o,

    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic [31:0]               w_data_o,
    output logic [3:0]                w_strb_o,
    output logic                      w_last_o,
    output logic [AXI_USER_WIDTH-1:0] w_user_o,

    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic [1:0]                b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   b_id_i,

    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    output logic [31:0]               ar_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   ar_id_o,
    output logic [AXI_USER_WIDTH-1:0] ar_user_o,
    output logic [7:0]                ar_len_o,
    output logic [2:0]                ar_size_o,
    output logic [1:0]                ar_burst_o,
    output logic [2:0]                ar_prot_o,
    output logic [3:0]                ar_cache_o,
    output logic                      ar_lock_o,
    output logic [3:0]                ar_qos_o,
    output logic [3:0]                ar_region_o,

    input  logic                      r_valid_i,
    output logic                      r_ready_o,
    input  logic [31:0]               r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   r_id_i,
    input  logic                      r_last_i
);

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        TCDM_RSP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  unused_axi_in;

    // A channel counts as complete once its handshake happened, now or earlier.
    assign aw_fire = aw_done | (aw_valid_o & aw_ready_i);
    assign w_fire  = w_done  | (w_valid_o  & w_ready_i);

    assign tcdm_gnt_o = (state == IDLE) & tcdm_req_i;

    assign aw_addr_o   = addr_q;
    assign aw_id_o     = '0;
    assign aw_user_o   = '0;
    assign aw_len_o    = 8'd0;
    assign aw_size_o   = 3'b010;
    assign aw_burst_o  = 2'b01;
    assign aw_prot_o   = '0;
    assign aw_cache_o  = '0;
    assign aw_lock_o   = 1'b0;
    assign aw_qos_o    = '0;
    assign aw_region_o = '0;
    assign aw_atop_o   = '0;

    assign w_data_o = wdata_q;
    assign w_strb_o = be_q;
    assign w_last_o = 1'b1;
    assign w_user_o = '0;

    assign ar_addr_o   = addr_q;
    assign ar_id_o     = '0;
    assign ar_user_o   = '0;
    assign ar_len_o    = 8'd0;
    assign ar_size_o   = 3'b010;
    assign ar_burst_o  = 2'b01;
    assign ar_prot_o   = '0;
    assign ar_cache_o  = '0;
    assign ar_lock_o   = 1'b0;
    assign ar_qos_o    = '0;
    assign ar_region_o = '0;

    assign unused_axi_in = ^{b_id_i, r_id_i, r_last_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            aw_valid_o     <= 1'b0;
            w_valid_o      <= 1'b0;
            b_ready_o      <= 1'b0;
            ar_valid_o     <= 1'b0;
            r_ready_o      <= 1'b0;
            tcdm_r_valid_o <= 1'b0;
            tcdm_r_rdata_o <= '0;
            tcdm_r_opc_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tcdm_req_i) begin
                        addr_q  <= {tcdm_add_i[31:2], 2'b00};
                        wdata_q <= tcdm_wdata_i;
                        be_q    <= tcdm_be_i;
                        if (tcdm_wen_i) begin
                            ar_valid_o <= 1'b1;
                            state      <= RD_REQ;
                        end else begin
                            aw_valid_o <= 1'b1;
                            w_valid_o  <= 1'b1;
                            state      <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_ready_i) aw_valid_o <= 1'b0;
                    if (w_ready_i)  w_valid_o  <= 1'b0;
                    aw_done <= aw_fire;
                    w_done  <= w_fire;
                    if (aw_fire && w_fire) begin
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        b_ready_o <= 1'b1;
                        state     <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_valid_i) begin
                        b_ready_o      <= 1'b0;
                        tcdm_r_opc_o   <= b_resp_i[1];
                        tcdm_r_rdata_o <= '0;
                        tcdm_r_valid_o <= 1'b1;
                        state          <= TCDM_RSP;
                    end
                end
                RD_REQ: begin
                    if (ar_ready_i) begin
                        ar_valid_o <= 1'b0;
                        r_ready_o  <= 1'b1;
                        state      <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_valid_i) begin
                        r_ready_o      <= 1'b0;
                        tcdm_r_opc_o   <= r_resp_i[1];
                        tcdm_r_rdata_o <= r_data_i;
                        tcdm_r_valid_o <= 1'b1;
                        state          <= TCDM_RSP;
                    end
                end
                TCDM_RSP: begin
                    tcdm_r_valid_o <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
